dcsk_chip_sequencer: RTL and testbench
======================================

# dcsk_chip_sequencer

Runtime-configurable DCSK symbol framer. It accepts one message bit per symbol over a valid/ready handshake and emits per-chip timing strobes that drive the chaos generator and modulator datapath. Each symbol is split into a reference half followed by a data half. The spreading factor is generalised from the fixed SF2..SF16 set to any power of two up to `2**MAX_SF_LOG2`, and a programmable chip-rate divider is added. Sits between the bit source and the modulator top.

## Interface
- `MAX_SF_LOG2`, default 4: largest supported SF is `2**MAX_SF_LOG2`; legal range 1..8.
- `CHIP_DIV`, default 1: clock cycles per chip; must be ≥1.
- Derived localparams:
  - `SF_SEL_W = max(1, $clog2(MAX_SF_LOG2))`
  - `IDX_W = max(1, MAX_SF_LOG2-1)`
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sf_sel`  in  `SF_SEL_W`  encodes `log2(SF)-1` (0 = SF2, 3 = SF16); sampled only at bit accept.
- `bit_valid`  in  1  message bit available.
- `bit_data`  in  1  message bit.
- `bit_ready`  out  1  block can accept a bit this cycle.
- `chip_stb`  out  1  one-cycle pulse per chip.
- `chip_phase`  out  1  0 = reference half, 1 = data half; valid with `chip_stb`.
- `chip_idx`  out  `IDX_W`  chip index within the current half; valid with `chip_stb`.
- `chip_bit`  out  1  latched bit of the current symbol.
- `sym_start`  out  1  pulse on the first reference chip strobe.
- `sym_end`  out  1  pulse on the last data chip strobe.
- `active_sf`  out  `SF_SEL_W`  `sf_sel` value latched for the current symbol.
- `busy`  out  1  high whenever the state is not IDLE.
- `sf_err`  out  1  one-cycle pulse when an out-of-range `sf_sel` was accepted.

## Operation
- FSM states: IDLE, REF, DATA. Reset state is IDLE.
- `bit_ready` = (state == IDLE) | (`chip_stb` & `sym_end`).
- Accept = `bit_valid & bit_ready`. On accept:
  - latch `bit_data` into `chip_bit`;
  - latch `sf_sel` into `active_sf`, clamped to `MAX_SF_LOG2-1` when larger; in the clamped case pulse `sf_err` on the next cycle;
  - clear the divider and chip counters;
  - go to REF.
- Half length `H = 2**(active_sf+1)/2 = 2**active_sf` chips. SF2 gives 1 reference chip and 1 data chip.
- REF: on each `chip_stb`, `chip_idx` counts 0..H-1. At the strobe with `chip_idx == H-1`, go to DATA and reset the index.
- DATA: same counting. At the strobe with `chip_idx == H-1`, assert `sym_end`. Go to REF if the same-cycle accept occurs, otherwise go to IDLE.
- `sf_sel` and `bit_data` changes while busy have no effect until the next accept.
- `bit_valid` without `bit_ready` is held by the source. No data loss; no accept while busy except in the last-chip cycle.
- Reset asserted mid-symbol: the symbol is abandoned immediately. No `sym_end` is produced. All outputs return to reset values.

## Timing
- Reset values:
  - state = IDLE;
  - `chip_stb`, `chip_phase`, `chip_idx`, `chip_bit`, `sym_start`, `sym_end`, `busy`, `sf_err` = 0;
  - `active_sf` = 0;
  - `bit_ready` = 1, since it is combinational from IDLE. The source must not assert `bit_valid` during reset.
- Accept at cycle T: `busy` = 1 from T+1. First `chip_stb` with `sym_start` occurs at T+CHIP_DIV, then every CHIP_DIV cycles.
- Symbol length is exactly `SF*CHIP_DIV` cycles. A back-to-back accept in the `sym_end` cycle gives a gapless strobe stream: the next `sym_start` follows `sym_end` by CHIP_DIV cycles.
- With `CHIP_DIV = 1`, `chip_stb` is continuously high while busy.
- `sf_err` is registered and appears at T+1.

## Structure
- Extend `spreading_factors_pkg` with:
  - `sf_half_len(sel)` function;
  - `chip_phase_t` enum {PH_REF, PH_DATA};
  - `seq_state_t` enum {IDLE, REF, DATA}.
- Keep the existing `sf_t` encoding, which is identical to `sf_sel` for `MAX_SF_LOG2 = 4`.
- Sub-module `chip_rate_div`: CHIP_DIV counter producing `chip_stb`, with a synchronous clear input driven on accept.

## Test plan
- Defaults, `sf_sel = 0`, one bit=1 → 2 strobes (`chip_phase` 0 then 1, `chip_idx` 0, 0), `sym_start` on the first, `sym_end` on the second, `busy` drops, `chip_bit = 1`.
- `sf_sel = 3`, `bit_valid` held high for 3 bits 1,0,1 → 48 consecutive strobes with no gap. Each symbol is 8 REF (idx 0..7) then 8 DATA. `chip_bit` changes exactly after each `sym_end`.
- `CHIP_DIV = 3`, `sf_sel = 1`, accept at T → strobes at T+3, T+6, T+9, T+12. `sym_end` at T+12.
- `sf_sel = 3` with `MAX_SF_LOG2 = 3` → `sf_err` pulse at T+1, `active_sf = 2`, 4+4 chips.
- `sf_sel` changed 0→2 mid-symbol → current symbol keeps its length; the next accepted symbol uses 4+4 chips.
- `rst_n` low during DATA chip 2 of SF16 → all outputs 0 immediately, `bit_ready = 1`. No `sym_end` occurs, and the next accept restarts from REF idx 0.

Source files
------------

// File: rtl/dcsk_chip_sequencer_pkg.sv
// Shared types and helpers for the DCSK chip sequencer.
// Covers the spreading-factor encoding, the FSM states and the half-length calculation.
package dcsk_chip_sequencer_pkg;

   typedef enum logic [1:0] {SF2, SF4, SF8, SF16} sf_t;
   typedef enum logic {PH_REF, PH_DATA} chip_phase_t;
   typedef enum logic [1:0] {IDLE, REF, DATA} seq_state_t;

   // Chips per half-symbol: SF = 2**(sel+1), so half = 2**sel.
   function automatic int sf_half_len(input int sel);
      return 1 << sel;
   endfunction

   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/dcsk_chip_sequencer_chip_rate_div.sv
// Divides the clock down to the chip rate.
// A clear on accept re-phases the counter so the first strobe lands CHIP_DIV cycles later.
module chip_rate_div #(
   parameter int CHIP_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic stb
);
   localparam int CW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHIP_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign stb = en & (cnt == LAST);
endmodule

// File: rtl/dcsk_chip_sequencer.sv
// DCSK symbol framer: one message bit per symbol, split into reference and data halves.
// It emits per-chip strobes with phase and index for the chaos generator and modulator.
module dcsk_chip_sequencer
   import dcsk_chip_sequencer_pkg::*;
#(
   parameter  int MAX_SF_LOG2 = 4,
   parameter  int CHIP_DIV    = 1,
   localparam int SF_SEL_W    = max1($clog2(MAX_SF_LOG2)),
   localparam int IDX_W       = max1(MAX_SF_LOG2 - 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SF_SEL_W-1:0] sf_sel,
   input  logic                bit_valid,
   input  logic                bit_data,
   output logic                bit_ready,
   output logic                chip_stb,
   output logic                chip_phase,
   output logic [IDX_W-1:0]    chip_idx,
   output logic                chip_bit,
   output logic                sym_start,
   output logic                sym_end,
   output logic [SF_SEL_W-1:0] active_sf,
   output logic                busy,
   output logic                sf_err
);
   seq_state_t          state;
   logic [IDX_W-1:0]    idx_q;
   logic                accept, last, sel_oor;
   logic [SF_SEL_W-1:0] sel_clamped;

   assign sel_oor     = int'(sf_sel) > (MAX_SF_LOG2 - 1);
   assign sel_clamped = sel_oor ? SF_SEL_W'(MAX_SF_LOG2 - 1) : sf_sel;

   assign busy       = (state != IDLE);
   assign chip_phase = (state == DATA) ? PH_DATA : PH_REF;
   assign chip_idx   = idx_q;
   assign last       = (idx_q == IDX_W'(sf_half_len(int'(active_sf)) - 1));
   assign sym_start  = chip_stb & (state == REF) & (idx_q == '0);
   assign sym_end    = chip_stb & (state == DATA) & last;
   // The last data chip doubles as an accept slot so back-to-back symbols stay gapless.
   assign bit_ready  = (state == IDLE) | (chip_stb & sym_end);
   assign accept     = bit_valid & bit_ready;

   chip_rate_div #(.CHIP_DIV(CHIP_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (busy),
      .stb   (chip_stb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_q     <= '0;
         chip_bit  <= 1'b0;
         active_sf <= '0;
         sf_err    <= 1'b0;
      end else begin
         sf_err <= 1'b0;
         if (accept) begin
            state     <= REF;
            idx_q     <= '0;
            chip_bit  <= bit_data;
            active_sf <= sel_clamped;
            sf_err    <= sel_oor;
         end else if (chip_stb) begin
            if (last) begin
               idx_q <= '0;
               state <= (state == REF) ? DATA : IDLE;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_dcsk_chip_sequencer.sv
// Directed bench for dcsk_chip_sequencer.
// Instance a uses the defaults, b uses CHIP_DIV=3, and c uses MAX_SF_LOG2=3.
module tb_dcsk_chip_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sf_sel = '0;
   logic       bit_data = 1'b0;
   logic       va = 1'b0, vb = 1'b0, vc = 1'b0;

   logic       a_ready, a_stb, a_phase, a_bit, a_start, a_end, a_busy, a_err;
   logic [2:0] a_idx;
   logic [1:0] a_sf;
   logic       b_ready, b_stb, b_phase, b_bit, b_start, b_end, b_busy, b_err;
   logic [2:0] b_idx;
   logic [1:0] b_sf;
   logic       c_ready, c_stb, c_phase, c_bit, c_start, c_end, c_busy, c_err;
   logic [1:0] c_idx;
   logic [1:0] c_sf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dcsk_chip_sequencer u_a (
      .clk(clk), .rst_n(rst_n), .sf_sel(sf_sel), .bit_valid(va), .bit_data(bit_data),
      .bit_ready(a_ready), .chip_stb(a_stb), .chip_phase(a_phase), .chip_idx(a_idx),
      .chip_bit(a_bit), .sym_start(a_start), .sym_end(a_end), .active_sf(a_sf),
      .busy(a_busy), .sf_err(a_err));

   dcsk_chip_sequencer #(.CHIP_DIV(3)) u_b (
      .clk(clk), .rst_n(rst_n), .sf_sel(sf_sel), .bit_valid(vb), .bit_data(bit_data),
      .bit_ready(b_ready), .chip_stb(b_stb), .chip_phase(b_phase), .chip_idx(b_idx),
      .chip_bit(b_bit), .sym_start(b_start), .sym_end(b_end), .active_sf(b_sf),
      .busy(b_busy), .sf_err(b_err));

   dcsk_chip_sequencer #(.MAX_SF_LOG2(3)) u_c (
      .clk(clk), .rst_n(rst_n), .sf_sel(sf_sel), .bit_valid(vc), .bit_data(bit_data),
      .bit_ready(c_ready), .chip_stb(c_stb), .chip_phase(c_phase), .chip_idx(c_idx),
      .chip_bit(c_bit), .sym_start(c_start), .sym_end(c_end), .active_sf(c_sf),
      .busy(c_busy), .sf_err(c_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic b3 [3];
      b3[0] = 1'b1; b3[1] = 1'b0; b3[2] = 1'b1;

      // reset state
      repeat (2) tick();
      chk("rst_outs", {a_stb, a_phase, a_idx, a_bit, a_start, a_end, a_sf, a_busy, a_err}, 32'd0);
      chk("rst_ready", a_ready, 32'd1);
      rst_n = 1'b1;
      tick();

      // SF2 single bit
      sf_sel = 2'd0; bit_data = 1'b1; va = 1'b1;
      tick();
      va = 1'b0; bit_data = 1'b0;
      chk("t1_c0", {a_stb, a_phase, a_idx, a_start, a_end, a_bit}, {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1});
      chk("t1_busy_err", {a_busy, a_err}, 32'b10);
      tick();
      chk("t1_c1", {a_stb, a_phase, a_idx, a_start, a_end, a_bit}, {1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1});
      chk("t1_ready_end", a_ready, 32'd1);
      tick();
      chk("t1_idle", {a_busy, a_stb, a_bit}, 32'b001);

      // SF16, three back-to-back bits
      sf_sel = 2'd3; bit_data = b3[0]; va = 1'b1;
      tick();
      for (int c = 0; c < 48; c++) begin
         chk($sformatf("t2_c%0d", c), {a_stb, a_phase, a_idx, a_start, a_end, a_bit},
             {1'b1, 1'((c % 16) >= 8), 3'(c % 8), 1'((c % 16) == 0), 1'((c % 16) == 15), b3[c / 16]});
         if ((c % 16) == 15) begin
            if ((c / 16) < 2) bit_data = b3[c / 16 + 1];
            else va = 1'b0;
         end
         tick();
      end
      chk("t2_idle", {a_busy, a_stb}, 32'd0);

      // sf_sel change mid-symbol
      sf_sel = 2'd0; bit_data = 1'b0; va = 1'b1;
      tick();
      va = 1'b0; sf_sel = 2'd2;
      chk("t5_c0", {a_stb, a_phase, a_idx, a_start, a_end, a_bit}, {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
      tick();
      chk("t5_keep_len", {a_stb, a_phase, a_idx, a_start, a_end, a_sf}, {1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 2'd0});
      tick();
      chk("t5_idle", a_busy, 32'd0);
      bit_data = 1'b1; va = 1'b1;
      tick();
      va = 1'b0;
      chk("t5_new_sf", a_sf, 32'd2);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("t5_n%0d", c), {a_stb, a_phase, a_idx, a_start, a_end, a_bit},
             {1'b1, 1'(c >= 4), 3'(c % 4), 1'(c == 0), 1'(c == 7), 1'b1});
         tick();
      end
      chk("t5_idle2", a_busy, 32'd0);

      // reset during DATA chip 2 of SF16
      sf_sel = 2'd3; bit_data = 1'b1; va = 1'b1;
      tick();
      va = 1'b0;
      repeat (10) tick();
      chk("t6_pre", {a_stb, a_phase, a_idx}, {1'b1, 1'b1, 3'd2});
      rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", {a_stb, a_phase, a_idx, a_bit, a_start, a_end, a_sf, a_busy, a_err}, 32'd0);
      chk("t6_rst_ready", a_ready, 32'd1);
      #2 rst_n = 1'b1;
      tick();
      chk("t6_no_end", {a_busy, a_end}, 32'd0);
      va = 1'b1;
      tick();
      va = 1'b0;
      chk("t6_restart", {a_stb, a_phase, a_idx, a_start, a_end, a_bit}, {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1});
      repeat (16) tick();
      chk("t6_idle", a_busy, 32'd0);

      // CHIP_DIV=3, SF4
      sf_sel = 2'd1; bit_data = 1'b1; vb = 1'b1;
      tick();
      vb = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         chk($sformatf("t3_k%0d", k), {b_stb, b_end, b_busy},
             {1'((k % 3) == 0 && k <= 12), 1'(k == 12), 1'(k <= 12)});
         if ((k % 3) == 0 && k <= 12)
            chk($sformatf("t3_ph%0d", k), {b_phase, b_idx},
                {1'(k >= 9), 3'((k >= 9) ? (k - 9) / 3 : (k - 3) / 3)});
         tick();
      end

      // out-of-range sf_sel clamps on MAX_SF_LOG2=3
      sf_sel = 2'd3; bit_data = 1'b0; vc = 1'b1;
      tick();
      vc = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("t4_c%0d", c), {c_stb, c_phase, c_idx, c_start, c_end},
             {1'b1, 1'(c >= 4), 2'(c % 4), 1'(c == 0), 1'(c == 7)});
         if (c == 0) chk("t4_err", {c_err, c_sf}, {1'b1, 2'd2});
         if (c == 1) chk("t4_err_clr", c_err, 32'd0);
         tick();
      end
      chk("t4_idle", c_busy, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
